// File: rtl/downlink_framer_if.sv
// Downlink framer bus: frame request/cancel, field inputs and serial output pair.
`timescale 1ns/1ps
interface downlink_framer_if;
  logic       start;
  logic       abort;
  logic       resolution_in;
  logic [2:0] compression_in;
  logic [2:0] repetition_in;
  logic       write_en;
  logic       downlink_bit;
  logic       busy;
  logic       done;

  // Requester side: drives the frame request and fields, observes the serial pair.
  modport master (
    output start, abort, resolution_in, compression_in, repetition_in,
    input  write_en, downlink_bit, busy, done
  );

  // Framer side.
  modport slave (
    input  start, abort, resolution_in, compression_in, repetition_in,
    output write_en, downlink_bit, busy, done
  );
endinterface

// File: rtl/downlink_framer.sv
// Downlink command framer: builds {PREAMBLE, resolution, compression, repetition}
// and shifts it out MSB first, one write_en strobe per BIT_PERIOD clocks,
// followed by GAP_CYCLES idle clocks and a one-clock done pulse.
`timescale 1ns/1ps
module downlink_framer #(
  parameter int         BIT_PERIOD = 16,
  parameter int         GAP_CYCLES = 32,
  parameter logic [7:0] PREAMBLE   = 8'b11011101
) (
  input logic             clock,
  input logic             reset,
  downlink_framer_if.slave bus
);

  localparam int FRAME_BITS = 15;
  localparam int PW = $clog2(BIT_PERIOD) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int BW = $clog2(FRAME_BITS) + 1;

  localparam logic [PW-1:0] PERIOD_LAST = PW'(BIT_PERIOD - 1);
  // The strobe register is set one edge before the period wraps, so the
  // strobe cycle is the last cycle of each bit period.
  localparam logic [PW-1:0] STROBE_AT   = PW'(BIT_PERIOD - 2);
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [PW-1:0]           period_cnt, period_next;
  logic [BW-1:0]           bit_cnt, bit_cnt_next;
  logic [GW-1:0]           gap_cnt, gap_next;
  logic [FRAME_BITS-1:0]   shift_reg, shift_next;
  logic                    write_en_q, write_en_next;
  logic                    bit_q, bit_next;
  logic                    busy_q, busy_next;
  logic                    done_q, done_next;
  logic [FRAME_BITS-1:0]   frame_word;

  assign frame_word = {PREAMBLE, bus.resolution_in, bus.compression_in, bus.repetition_in};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state, counter, shift-register and output computation.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next    = state;
    period_next   = period_cnt;
    bit_cnt_next  = bit_cnt;
    gap_next      = gap_cnt;
    shift_next    = shift_reg;
    write_en_next = 1'b0;
    bit_next      = bit_q;
    busy_next     = busy_q;
    done_next     = 1'b0;

    unique case (state)
      IDLE: begin
        bit_next  = 1'b0;
        busy_next = 1'b0;
        // abort wins over a simultaneous start.
        if (bus.start && !bus.abort) begin
          state_next   = SEND;
          shift_next   = frame_word;
          bit_next     = frame_word[FRAME_BITS-1];
          period_next  = '0;
          bit_cnt_next = '0;
          busy_next    = 1'b1;
        end
      end

      SEND: begin
        if (bus.abort) begin
          state_next   = IDLE;
          bit_next     = 1'b0;
          busy_next    = 1'b0;
          period_next  = '0;
          bit_cnt_next = '0;
        end else begin
          if (period_cnt == STROBE_AT) write_en_next = 1'b1;
          if (period_cnt == PERIOD_LAST) begin
            period_next = '0;
            // The edge that ends strobe k presents bit k+1.
            if (bit_cnt == LAST_BIT) begin
              state_next   = GAP;
              gap_next     = '0;
              bit_next     = 1'b0;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = bit_cnt + BW'(1);
              shift_next   = {shift_reg[FRAME_BITS-2:0], 1'b0};
              bit_next     = shift_reg[FRAME_BITS-2];
            end
          end else begin
            period_next = period_cnt + PW'(1);
          end
        end
      end

      GAP: begin
        if (bus.abort) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          gap_next   = '0;
        end else if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          gap_next   = '0;
        end else begin
          gap_next = gap_cnt + GW'(1);
        end
      end

      default: begin
        state_next = IDLE;
        bit_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shift_reg  <= '0;
      write_en_q <= 1'b0;
      bit_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      period_cnt <= period_next;
      bit_cnt    <= bit_cnt_next;
      gap_cnt    <= gap_next;
      shift_reg  <= shift_next;
      write_en_q <= write_en_next;
      bit_q      <= bit_next;
      busy_q     <= busy_next;
      done_q     <= done_next;
    end
  end

  assign bus.write_en     = write_en_q;
  assign bus.downlink_bit = bit_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_downlink_framer.sv
// Scoreboarded bench for downlink_framer: one instance at BIT_PERIOD=16/GAP=32,
// one at BIT_PERIOD=2/GAP=1 for back-to-back frames.
`timescale 1ns/1ps
module tb_downlink_framer;

  localparam logic [7:0] PRE = 8'b11011101;
  localparam int BP_A = 16, GAP_A = 32;
  localparam int BP_B = 2,  GAP_B = 1;

  typedef struct {
    logic b;
    int   cyc;
  } strobe_t;

  typedef struct {
    int          cyc;
    logic [14:0] word;
  } done_t;

  logic clock;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  strobe_t     sb_q[2][$];
  done_t       done_q[2][$];
  int          strobes[2];
  logic [14:0] cap[2];
  logic        res_seen[2];

  downlink_framer_if bus_a ();
  downlink_framer_if bus_b ();

  downlink_framer #(.BIT_PERIOD(BP_A), .GAP_CYCLES(GAP_A), .PREAMBLE(PRE)) u_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  downlink_framer #(.BIT_PERIOD(BP_B), .GAP_CYCLES(GAP_B), .PREAMBLE(PRE)) u_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  logic we_s[2], bit_s[2], busy_s[2], done_s[2];
  assign we_s[0]   = bus_a.write_en;
  assign bit_s[0]  = bus_a.downlink_bit;
  assign busy_s[0] = bus_a.busy;
  assign done_s[0] = bus_a.done;
  assign we_s[1]   = bus_b.write_en;
  assign bit_s[1]  = bus_b.downlink_bit;
  assign busy_s[1] = bus_b.busy;
  assign done_s[1] = bus_b.done;

  initial clock = 1'b0;
  always #500 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and done pulse.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (we_s[d] === 1'b1) begin
        cap[d] = {cap[d][13:0], bit_s[d]};
        if (sb_q[d].size() == 0) begin
          check($sformatf("unexpected strobe dut%0d", d), 32'(we_s[d]), 32'd0);
        end else begin
          strobe_t e;
          e = sb_q[d].pop_front();
          check($sformatf("strobe bit dut%0d", d), 32'(bit_s[d]), 32'(e.b));
          check($sformatf("strobe cycle dut%0d", d), cyc, e.cyc);
          strobes[d]++;
        end
      end
      if (done_s[d] === 1'b1) begin
        if (done_q[d].size() == 0) begin
          check($sformatf("unexpected done dut%0d", d), 32'(done_s[d]), 32'd0);
        end else begin
          done_t e;
          e = done_q[d].pop_front();
          check($sformatf("done cycle dut%0d", d), cyc, e.cyc);
          check($sformatf("frame word dut%0d", d), 32'(cap[d]), 32'(e.word));
          check($sformatf("strobes per frame dut%0d", d), strobes[d], 15);
          check($sformatf("busy at done dut%0d", d), 32'(busy_s[d]), 32'd0);
        end
        if (cap[d][14:7] == PRE) res_seen[d] = cap[d][6];
        strobes[d] = 0;
      end
    end
  end

  // Expected strobes for a frame whose start edge left the counter at e0.
  task automatic push_frame(input int d, input int e0, input int bp, input int gap,
                            input logic [14:0] word);
    for (int k = 0; k < 15; k++) begin
      strobe_t s;
      done_t   dn;
      s.b   = word[14-k];
      s.cyc = e0 + (k + 1) * bp - 1;
      sb_q[d].push_back(s);
      if (k == 14) begin
        dn.cyc  = e0 + 15 * bp + gap;
        dn.word = word;
        done_q[d].push_back(dn);
      end
    end
  endtask

  // One start pulse on DUT A; returns the cycle count right after the start edge.
  task automatic launch_a(input logic res, input logic [2:0] comp, input logic [2:0] rep,
                          input logic [14:0] word, output int e0);
    @(negedge clock);
    bus_a.resolution_in  = res;
    bus_a.compression_in = comp;
    bus_a.repetition_in  = rep;
    bus_a.start          = 1'b1;
    @(posedge clock);
    #1;
    e0 = cyc;
    push_frame(0, e0, BP_A, GAP_A, word);
    @(negedge clock);
    bus_a.start = 1'b0;
    check("busy after start", 32'(bus_a.busy), 32'd1);
  endtask

  task automatic wait_done_a(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (bus_a.done === 1'b1) begin
        #1;
        return;
      end
    end
    check("done timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #(20000 * 1000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    strobes  = '{0, 0};
    cap      = '{15'd0, 15'd0};
    res_seen = '{1'b0, 1'b0};
    bus_a.start = 1'b0; bus_a.abort = 1'b0;
    bus_a.resolution_in = 1'b0; bus_a.compression_in = 3'd0; bus_a.repetition_in = 3'd0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0;
    bus_b.resolution_in = 1'b0; bus_b.compression_in = 3'd0; bus_b.repetition_in = 3'd0;
    reset = 1'b0;
    #100;
    check("reset write_en", 32'(bus_a.write_en), 32'd0);
    check("reset downlink_bit", 32'(bus_a.downlink_bit), 32'd0);
    check("reset busy", 32'(bus_a.busy), 32'd0);
    check("reset done", 32'(bus_a.done), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Frame 1: literal expected word from the bit sequence 1101_1101 1 101 010.
    launch_a(1'b1, 3'b101, 3'b010, 15'b110111011101010, e0);
    wait_done_a(400);
    check("loopback resolution after frame 1", 32'(res_seen[0]), 32'd1);
    @(negedge clock);
    check("busy after gap", 32'(bus_a.busy), 32'd0);

    // Frame 2: resolution cleared.
    launch_a(1'b0, 3'b011, 3'b110, {PRE, 1'b0, 3'b011, 3'b110}, e0);
    wait_done_a(400);
    check("loopback resolution after frame 2", 32'(res_seen[0]), 32'd0);

    // Fields changed at bit 3, start re-pulsed at bit 5: frame unaffected, not queued.
    launch_a(1'b1, 3'b001, 3'b111, {PRE, 1'b1, 3'b001, 3'b111}, e0);
    repeat (3 * BP_A + 2) @(negedge clock);
    bus_a.resolution_in  = 1'b0;
    bus_a.compression_in = 3'b110;
    bus_a.repetition_in  = 3'b000;
    repeat (2 * BP_A) @(negedge clock);
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    wait_done_a(400);
    repeat (20 * BP_A) @(negedge clock);
    check("no queued frame", 32'(bus_a.busy), 32'd0);
    check("scoreboard drained", sb_q[0].size(), 0);

    // Abort during bit 9.
    launch_a(1'b1, 3'b010, 3'b101, {PRE, 1'b1, 3'b010, 3'b101}, e0);
    repeat (9 * BP_A + 2) @(negedge clock);
    bus_a.abort = 1'b1;
    @(negedge clock);
    bus_a.abort = 1'b0;
    check("abort busy", 32'(bus_a.busy), 32'd0);
    check("abort write_en", 32'(bus_a.write_en), 32'd0);
    check("abort downlink_bit", 32'(bus_a.downlink_bit), 32'd0);
    check("strobes left after abort", sb_q[0].size(), 6);
    sb_q[0].delete();
    done_q[0].delete();
    strobes[0] = 0;
    repeat (20 * BP_A) @(negedge clock);
    launch_a(1'b0, 3'b111, 3'b001, {PRE, 1'b0, 3'b111, 3'b001}, e0);
    wait_done_a(400);

    // Reset asserted during the gap, held 3 clocks.
    launch_a(1'b1, 3'b100, 3'b011, {PRE, 1'b1, 3'b100, 3'b011}, e0);
    repeat (15 * BP_A + 4) @(negedge clock);
    reset = 1'b0;
    #1;
    check("gap reset busy", 32'(bus_a.busy), 32'd0);
    check("gap reset write_en", 32'(bus_a.write_en), 32'd0);
    check("gap reset downlink_bit", 32'(bus_a.downlink_bit), 32'd0);
    check("gap reset done", 32'(bus_a.done), 32'd0);
    check("strobes before gap reset", sb_q[0].size(), 0);
    done_q[0].delete();
    strobes[0] = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (60) @(negedge clock);
    check("idle after reset release", 32'(bus_a.busy), 32'd0);

    // DUT B: start held high, three back-to-back frames 32 clocks apart.
    @(negedge clock);
    bus_b.resolution_in  = 1'b0;
    bus_b.compression_in = 3'b110;
    bus_b.repetition_in  = 3'b001;
    bus_b.start          = 1'b1;
    @(posedge clock);
    #1;
    e0 = cyc;
    for (int n = 0; n < 3; n++)
      push_frame(1, e0 + n * (15 * BP_B + GAP_B + 1), BP_B, GAP_B, {PRE, 1'b0, 3'b110, 3'b001});
    repeat (3 * (15 * BP_B + GAP_B + 1)) @(negedge clock);
    bus_b.start = 1'b0;
    repeat (40) @(negedge clock);
    check("b2b strobes drained", sb_q[1].size(), 0);
    check("b2b dones drained", done_q[1].size(), 0);
    check("b2b idle", 32'(bus_b.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
